part_2_init_ctrl: RTL
=====================

# part_2_init_ctrl

Initiator-side step controller for the part_2 co-simulation bridge; it is the counterpart of the target-side fringe interface. On each rising edge of mission clock clk_0_h it snapshots the downloaded channel vectors and streams them one beat per channel toward the target, then holds the mission clocks frozen until the target's response beat ({valid, o_data}) returns. It sits between the initiator DUT partition and the transport bridge, with a watchdog that guards every outstanding step.

## Interface
Parameters:
- N_CH, 3, number of downloaded channels (beat index 0..N_CH-1)
- DW, 9, beat width ({wen, data[7:0]})
- N_CLK, 4, number of mission clocks controlled by freeze_clk_o
- WDOG_MAX, 10000, clk_i cycles allowed in WAIT before error

Ports:
- clk_i  in  1  utility clock; all logic on posedge
- rst_ni  in  1  asynchronous active-low reset
- clk_0_h  in  1  mission clock level, sampled on clk_i
- ch_data_i  in  N_CH*DW  channel vectors, channel k at [k*DW +: DW]
- put_valid_o  out  1  beat toward target valid
- put_ready_i  in  1  bridge accepts beat
- put_idx_o  out  2  channel index of current beat
- put_data_o  out  DW  beat payload
- get_valid_i  in  1  response beat from target valid
- get_ready_o  out  1  controller accepts response
- get_data_i  in  DW  response {valid, o_data}
- valid_o  out  1  one-cycle pulse: delivered response
- o_data_o  out  8  delivered data, held until next delivery
- freeze_clk_o  out  N_CLK  mission clock block, all bits equal
- busy_o  out  1  step outstanding (SEND or WAIT)
- ovf_o  out  1  sticky: edge lost while one already pending
- wdog_err_o  out  1  sticky watchdog error

## Operation
- Edge detect: clk_0_d registers clk_0_h; edge = clk_0_h & ~clk_0_d.
- States: IDLE, SEND, WAIT, ERR.
- IDLE: on edge or pending, snapshot ch_data_i, idx<=0, clear pending, go SEND.
- SEND: put_valid_o=1, put_idx_o=idx, put_data_o=snapshot[idx]; payload stable while valid & !ready. On handshake: idx==N_CH-1 -> WAIT, wdog<=0; else idx+1.
- WAIT: get_ready_o=1; wdog increments each cycle. On get_valid_i: o_data_o<=get_data_i[7:0], valid_o<=get_data_i[8] pulsed one cycle, go IDLE. If wdog reaches WDOG_MAX with no response: wdog_err_o<=1, go ERR.
- ERR: terminal; freeze held, no handshakes; exit only via rst_ni.
- Edge in SEND/WAIT: pending<=1. Edge while pending already 1: ovf_o<=1, edge dropped.
- freeze_clk_o = all ones in SEND, WAIT, ERR; zero in IDLE. busy_o = SEND|WAIT.
- Reset values: all outputs 0, state IDLE, clk_0_d 0, pending 0, wdog 0.

## Timing
- Edge seen in cycle t -> snapshot at end of t, put_valid_o and freeze in t+1.
- Beats ready-paced; with put_ready_i held 1, N_CH beats in t+1..t+N_CH, WAIT from t+N_CH+1.
- Response accepted cycle r -> valid_o, o_data_o, freeze low at r+1; new step earliest r+2 if pending.
- Response arriving in same cycle as watchdog limit: response wins.
- get_valid_i outside WAIT: ignored (get_ready_o=0).
- Reset mid-step: asynchronous return to reset values; in-flight beat abandoned.

## Structure
- Package part_2_cs_pkg: state enum (IDLE, SEND, WAIT, ERR), DW/N_CH defaults, beat typedef {logic wen; logic [7:0] data}.
- Sub-module part_2_edge_det: registered rising-edge detector (clk_i, rst_ni, level in, pulse out), reused on target side.

## Test plan
- Edge with ch_data_i = {9'h1AA, 9'h055, 9'h101}, ready=1, response 9'h1C3 after 5 cycles -> beats idx0 9'h101, idx1 9'h055, idx2 9'h1AA; valid_o pulse with o_data_o=8'hC3; freeze high throughout, low after.
- put_ready_i low for 3 cycles on beat 1 -> put_data_o/put_idx_o stable, no beat duplicated or skipped.
- Two edges during WAIT -> ovf_o=1, exactly one further step after response.
- WDOG_MAX=16, no response -> wdog_err_o at cycle 16 of WAIT, freeze stays all ones, later get_valid_i ignored.
- Response 9'h07F -> valid_o stays 0, o_data_o=8'h7F, state returns IDLE.
- rst_ni low mid-SEND -> all outputs 0 immediately; next edge restarts from idx 0.

Source files
------------

// File: rtl/part_2_cs_pkg.sv
// Shared types for the part_2 co-simulation bridge: step-controller states,
// default channel geometry and the beat layout used on both sides of the link.
package part_2_cs_pkg;

   localparam int unsigned N_CH_DEF = 3;
   localparam int unsigned DW_DEF   = 9;

   typedef enum logic [1:0] {
      StIdle,
      StSend,
      StWait,
      StErr
   } state_e;

   typedef struct packed {
      logic       wen;
      logic [7:0] data;
   } beat_t;

endpackage

// File: rtl/part_2_edge_det.sv
// Registered rising-edge detector: pulse is high in the cycle where the
// sampled level is 1 and was 0 in the previous clk_i cycle.
module part_2_edge_det (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic level_i,
   output logic pulse_o
);

   logic level_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         level_q <= 1'b0;
      end else begin
         level_q <= level_i;
      end
   end

   assign pulse_o = level_i & ~level_q;

endmodule

// File: rtl/part_2_init_ctrl.sv
// Initiator-side step controller: snapshots channel vectors on each mission
// clock edge, streams them as beats, and freezes mission clocks until the reply.
module part_2_init_ctrl
   import part_2_cs_pkg::*;
#(
   parameter int unsigned N_CH     = N_CH_DEF,
   parameter int unsigned DW       = DW_DEF,
   parameter int unsigned N_CLK    = 4,
   parameter int unsigned WDOG_MAX = 10000
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               clk_0_h,
   input  logic [N_CH*DW-1:0] ch_data_i,
   output logic               put_valid_o,
   input  logic               put_ready_i,
   output logic [1:0]         put_idx_o,
   output logic [DW-1:0]      put_data_o,
   input  logic               get_valid_i,
   output logic               get_ready_o,
   input  logic [DW-1:0]      get_data_i,
   output logic               valid_o,
   output logic [7:0]         o_data_o,
   output logic [N_CLK-1:0]   freeze_clk_o,
   output logic               busy_o,
   output logic               ovf_o,
   output logic               wdog_err_o
);

   localparam int unsigned WdogW = $clog2(WDOG_MAX + 1);
   localparam int unsigned BeatW = $bits(beat_t);

   state_e             state_q, state_d;
   logic [1:0]         idx_q, idx_d;
   logic [N_CH*DW-1:0] snap_q, snap_d;
   logic               pend_q, pend_d;
   logic               ovf_q, ovf_d;
   logic               err_q, err_d;
   logic [WdogW-1:0]   wdog_q, wdog_d;
   logic               valid_q, valid_d;
   logic [7:0]         odata_q, odata_d;

   logic               clk_0_edge;
   logic [DW-1:0]      cur_beat;
   beat_t              rsp;

   part_2_edge_det u_edge_det (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .level_i (clk_0_h),
      .pulse_o (clk_0_edge)
   );

   assign rsp = beat_t'(get_data_i[BeatW-1:0]);

   always_comb begin
      cur_beat = '0;
      for (int unsigned k = 0; k < N_CH; k++) begin
         if (idx_q == 2'(k)) begin
            cur_beat = snap_q[k*DW +: DW];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      snap_d  = snap_q;
      pend_d  = pend_q;
      ovf_d   = ovf_q;
      err_d   = err_q;
      wdog_d  = wdog_q;
      valid_d = 1'b0;
      odata_d = odata_q;

      // At most one edge can be queued; a second one is lost and flagged.
      if (clk_0_edge && pend_q && (state_q != StErr)) begin
         ovf_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (clk_0_edge || pend_q) begin
               snap_d  = ch_data_i;
               idx_d   = '0;
               pend_d  = 1'b0;
               state_d = StSend;
            end
         end
         StSend: begin
            if (clk_0_edge && !pend_q) begin
               pend_d = 1'b1;
            end
            if (put_ready_i) begin
               if (idx_q == 2'(N_CH - 1)) begin
                  wdog_d  = '0;
                  state_d = StWait;
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end
         end
         StWait: begin
            if (clk_0_edge && !pend_q) begin
               pend_d = 1'b1;
            end
            // A reply in the final allowed cycle still beats the watchdog.
            if (get_valid_i) begin
               odata_d = rsp.data;
               valid_d = rsp.wen;
               state_d = StIdle;
            end else if (wdog_q == WdogW'(WDOG_MAX - 1)) begin
               err_d   = 1'b1;
               state_d = StErr;
            end else begin
               wdog_d = wdog_q + WdogW'(1);
            end
         end
         StErr: begin
            state_d = StErr;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         idx_q   <= '0;
         snap_q  <= '0;
         pend_q  <= 1'b0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
         wdog_q  <= '0;
         valid_q <= 1'b0;
         odata_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         snap_q  <= snap_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
         wdog_q  <= wdog_d;
         valid_q <= valid_d;
         odata_q <= odata_d;
      end
   end

   always_comb begin
      put_valid_o  = (state_q == StSend);
      put_idx_o    = put_valid_o ? idx_q : 2'd0;
      put_data_o   = put_valid_o ? cur_beat : '0;
      get_ready_o  = (state_q == StWait);
      freeze_clk_o = (state_q == StIdle) ? '0 : '1;
      busy_o       = (state_q == StSend) || (state_q == StWait);
   end

   assign valid_o    = valid_q;
   assign o_data_o   = odata_q;
   assign ovf_o      = ovf_q;
   assign wdog_err_o = err_q;

endmodule
